// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: iterative SLL/SRL/SRA sequencer with valid/ready handshakes on both sides.
// Optional SHIFT_SEQ_FAST4_EN: take 4-bit steps while at least four positions remain.
module shift_seq_ctrl #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         op_i,
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               flush_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [XLEN-1:0]    data_o,
    output logic               busy_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [XLEN-1:0]    data_q, data_d, step_res;
    logic [SHAMT_W-1:0] cnt_q, cnt_d, step_sz;
    logic               fill;
    logic               right;
    always_comb begin
        right = op_q[0];
        fill  = (op_q == 2'b11) & data_q[XLEN-1];
`ifdef SHIFT_SEQ_FAST4_EN
        step_sz  = (cnt_q >= SHAMT_W'(4)) ? SHAMT_W'(4) : SHAMT_W'(1);
        step_res = (cnt_q >= SHAMT_W'(4))
                 ? (right ? {{4{fill}}, data_q[XLEN-1:4]} : {data_q[XLEN-5:0], 4'b0})
                 : (right ? {fill, data_q[XLEN-1:1]} : {data_q[XLEN-2:0], 1'b0});
`else
        step_sz  = SHAMT_W'(1);
        step_res = right ? {fill, data_q[XLEN-1:1]} : {data_q[XLEN-2:0], 1'b0};
`endif
    end
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                op_d    = op_i;
                data_d  = data_i;
                cnt_d   = shamt_i;
                state_d = (shamt_i == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                data_d  = step_res;
                cnt_d   = cnt_q - step_sz;
                state_d = (cnt_d == '0) ? DONE : SHIFT;
            end
            DONE:    state_d = res_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        // flush wins over any accept or step decided above
        if (flush_i) begin
            state_d = IDLE;
            op_d    = op_q;
            data_d  = data_q;
            cnt_d   = '0;
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end
    assign req_ready_o = (state_q == IDLE);
    assign res_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign data_o      = data_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: random and directed stimulus checked every cycle against a behavioural model.
module tb_shift_seq_ctrl;
`ifdef SHIFT_SEQ_FAST4_EN
    localparam bit FAST = 1;
`else
    localparam bit FAST = 0;
`endif
    logic        clk_i = 0, rst_n_i = 0, req_valid_i = 0, flush_i = 0, res_ready_i = 0;
    logic [1:0]  op_i = 0;
    logic [31:0] data_i = 0;
    logic [4:0]  shamt_i = 0;
    logic        req_ready_o, res_valid_o, busy_o;
    logic [31:0] data_o;
    int          n_cmp = 0, n_fail = 0;
    int          lat;

    always #5 clk_i = ~clk_i;

    shift_seq_ctrl #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .op_i(op_i), .data_i(data_i), .shamt_i(shamt_i), .flush_i(flush_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .data_o(data_o), .busy_o(busy_o)
    );

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        logic signed [31:0] sd;
        sd = d;
        if (op == 2'b01) return d >> s;
        if (op == 2'b11) return sd >>> s;
        return d << s;
    endfunction

    function automatic int ref_lat(input logic [4:0] s);
        int n;
        n = int'(s);
        return FAST ? 1 + n / 4 + n % 4 : 1 + n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: 0 idle, 1 working (m_wait cycles to go), 2 result presented
    int          m_phase = 0, m_wait = 0;
    logic [31:0] m_res = 0;
    bit          m_any = 0;
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_phase = 0; m_wait = 0; m_any = 0;
        end else if (flush_i) m_phase = 0;
        else if (m_phase == 0) begin
            if (req_valid_i) begin
                m_res   = ref_shift(op_i, data_i, shamt_i);
                m_wait  = ref_lat(shamt_i) - 1;
                m_any   = 1;
                m_phase = (m_wait == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            m_wait--;
            if (m_wait == 0) m_phase = 2;
        end else if (res_ready_i) m_phase = 0;
    end

    always @(negedge clk_i) begin
        chk("req_ready", 32'(req_ready_o), 32'(m_phase == 0));
        chk("res_valid", 32'(res_valid_o), 32'(m_phase == 2));
        chk("busy", 32'(busy_o), 32'(m_phase != 0));
        if (m_phase == 2) chk("data_o", data_o, m_res);
        else if (!m_any) chk("data_o_init", data_o, 32'h0);
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        req_valid_i = 1; op_i = op; data_i = d; shamt_i = s;
        tick();
        req_valid_i = 0;
    endtask

    task automatic wait_valid(output int l);
        l = 1;
        while (!res_valid_o && l < 100) begin
            tick();
            l++;
        end
    endtask

    initial begin
        repeat (3) tick();
        rst_n_i = 1;
        tick();
        res_ready_i = 1;
        // SLL 1 by 31
        issue(2'b00, 32'h0000_0001, 5'd31);
        chk("t2_busy", 32'(busy_o), 32'h1);
        wait_valid(lat);
        chk("t2_lat", lat, FAST ? 11 : 32);
        chk("t2_data", data_o, 32'h8000_0000);
        tick();
        // SRA / SRL by 4
        issue(2'b11, 32'h8000_00F0, 5'd4);
        wait_valid(lat);
        chk("t3_lat", lat, FAST ? 2 : 5);
        chk("t3_sra", data_o, 32'hF800_000F);
        tick();
        issue(2'b01, 32'h8000_00F0, 5'd4);
        wait_valid(lat);
        chk("t3_srl", data_o, 32'h0800_000F);
        tick();
        // shamt 0 with writeback stalled
        res_ready_i = 0;
        issue(2'b01, 32'hDEAD_BEEF, 5'd0);
        chk("t4_valid", 32'(res_valid_o), 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold", data_o, 32'hDEAD_BEEF);
            chk("t4_noready", 32'(req_ready_o), 32'h0);
            tick();
        end
        res_ready_i = 1;
        tick();
        chk("t4_idle", 32'(req_ready_o), 32'h1);
        chk("t4_novalid", 32'(res_valid_o), 32'h0);
        // flush at T0+5
        issue(2'b00, 32'h0001_2345, 5'd10);
        for (int i = 1; i < 5; i++) begin
            chk("t5_novalid", 32'(res_valid_o), 32'h0);
            tick();
        end
        chk("t5_t5valid", 32'(res_valid_o), 32'(FAST));
        flush_i = 1;
        tick();
        flush_i = 0;
        chk("t5_ready", 32'(req_ready_o), 32'h1);
        chk("t5_dropped", 32'(res_valid_o), 32'h0);
        issue(2'b10, 32'h0000_0001, 5'd3);
        wait_valid(lat);
        chk("t5_rsv_sll", data_o, 32'h0000_0008);
        tick();
        // reset at T0+3
        issue(2'b00, 32'hA5A5_0F0F, 5'd20);
        tick();
        tick();
        rst_n_i = 0;
        #1;
        chk("t1_ready", 32'(req_ready_o), 32'h1);
        chk("t1_valid", 32'(res_valid_o), 32'h0);
        chk("t1_busy", 32'(busy_o), 32'h0);
        chk("t1_data", data_o, 32'h0);
        tick();
        rst_n_i = 1;
        tick();
        issue(2'b11, 32'hF000_0000, 5'd8);
        wait_valid(lat);
        chk("t1_lat", lat, FAST ? 3 : 9);
        chk("t1_data_after", data_o, 32'hFFF0_0000);
        tick();
        // random traffic
        for (int c = 0; c < 40000; c++) begin
            int r;
            r = int'($urandom % 8);
            flush_i     = ($urandom % 64) == 0;
            req_valid_i = ($urandom % 4) != 0;
            op_i        = 2'($urandom);
            data_i      = $urandom;
            shamt_i     = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom);
            res_ready_i = ($urandom % 4) != 0;
            tick();
        end
        req_valid_i = 0; flush_i = 0; res_ready_i = 1;
        repeat (40) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
